instr_fetch_unit: RTL and testbench

- Fetch stage sitting directly upstream of the instruction decoder.
- Generates sequential PCs and issues requests to instruction memory over a request/grant, in-order response interface.
- Buffers returned 32-bit instruction words in a small FIFO and presents them to the decoder with a valid/ready handshake.
- Supports a branch/jump redirect that flushes buffered and in-flight fetches.

---
 rtl/instr_fetch_unit.sv | 127 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: sequential PC generation, credit-limited imem requests,
// in-order response buffering and redirect flush of buffered and in-flight words.
module instr_fetch_unit #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
);

  localparam int             PW      = $clog2(FIFO_DEPTH);
  localparam int             CW      = PW + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {FETCH, FLUSH} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc;
  logic [CW-1:0]     occ, outstanding, outstanding_nx;

  logic [31:0]       buf_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] buf_pc   [FIFO_DEPTH];
  logic [PW-1:0]     buf_wr, buf_rd;

  // PC tags of granted requests, consumed in order as responses return.
  logic [ADDR_W-1:0] tag_pc [FIFO_DEPTH];
  logic [PW-1:0]     tag_wr, tag_rd;

  logic grant, rsp, push, pop;

  assign grant = imem_req & imem_gnt;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp   = imem_rvalid & (outstanding != '0);
  assign push  = rsp & (state == FETCH) & ~redirect;
  assign pop   = instr_valid & instr_ready;

  assign outstanding_nx = outstanding + CW'(grant) - CW'(rsp);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!rst_n) state <= FETCH;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first, so no path through this block can infer a latch.
    state_nx = state;
    if (redirect)
      state_nx = (outstanding_nx != '0) ? FLUSH : FETCH;
    else if (state == FLUSH && outstanding_nx == '0)
      state_nx = FETCH;
  end

  // Output logic: request depends only on registered state; rst_n keeps it low in reset
  always_comb begin
    imem_req = 1'b0;
    if (rst_n && state == FETCH)
      imem_req = (occ + outstanding) < DEPTH_C;
  end

  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        pc <= RESET_PC;
    else if (redirect) pc <= redirect_pc;
    else if (grant)    pc <= pc + ADDR_W'(4);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
    end else begin
      outstanding <= outstanding_nx;
      if (grant) tag_wr <= tag_wr + 1'b1;
      if (rsp)   tag_rd <= tag_rd + 1'b1;
    end
  end

  // NOTE: storage arrays carry no reset; occupancy/pointers are reset and the
  // outputs are gated by instr_valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (grant) tag_pc[tag_wr] <= pc;
    if (push) begin
      buf_data[buf_wr] <= imem_rdata;
      buf_pc[buf_wr]   <= tag_pc[tag_rd];
    end
  end

  // Redirect discards everything still buffered after this cycle's pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ    <= '0;
      buf_wr <= '0;
      buf_rd <= '0;
    end else if (redirect) begin
      occ    <= '0;
      buf_wr <= '0;
      buf_rd <= '0;
    end else begin
      occ <= occ + CW'(push) - CW'(pop);
      if (push) buf_wr <= buf_wr + 1'b1;
      if (pop)  buf_rd <= buf_rd + 1'b1;
    end
  end

  assign instr_valid = (occ != '0);
  assign instr       = instr_valid ? buf_data[buf_rd] : '0;
  assign instr_pc    = instr_valid ? buf_pc[buf_rd]   : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: an in-order memory model feeds expected
// words to a queue that a separate monitor drains on every decoder handshake.
module tb_instr_fetch_unit;

  localparam int          ADDR_W   = 32;
  localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  typedef struct { logic [31:0] addr; logic [31:0] pc; bit stale; } mem_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

  mem_t        memq[$];
  exp_t        sb[$];
  mem_t        cur_rsp;
  bit          cur_rsp_v;
  bit          rsp_en;
  bit          spurious;
  logic [31:0] model_pc;
  int          tests;
  int          fails;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1BAD_F00D;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: sample the grant mid-cycle, then after the edge update the
  // reference model and drive the memory response for the following edge.
  task automatic step();
    logic        g;
    logic [31:0] ga;
    @(negedge clk);
    g  = imem_req && imem_gnt;
    ga = imem_addr;
    if (g) check("grant_addr", ga, model_pc);
    @(posedge clk);
    #1;
    if (g) begin
      memq.push_back('{addr: ga, pc: model_pc, stale: 1'b0});
      model_pc = model_pc + 32'd4;
    end
    if (redirect) begin
      sb.delete();
      foreach (memq[i]) memq[i].stale = 1'b1;
      model_pc = redirect_pc;
    end else if (cur_rsp_v && !cur_rsp.stale) begin
      sb.push_back('{pc: cur_rsp.pc, data: mem_word(cur_rsp.pc)});
    end
    cur_rsp_v = 1'b0;
    if (spurious) begin
      cur_rsp   = '{addr: 32'hBAD0_0000, pc: 32'h0, stale: 1'b1};
      cur_rsp_v = 1'b1;
    end else if (rsp_en && memq.size() > 0) begin
      cur_rsp   = memq.pop_front();
      cur_rsp_v = 1'b1;
    end
    imem_rvalid = cur_rsp_v;
    imem_rdata  = cur_rsp_v ? mem_word(cur_rsp.addr) : 32'h0;
  endtask

  // Monitor: every accepted word must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_instr: got pc %h instr %h, none expected", instr_pc, instr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("instr_pc", instr_pc, e.pc);
        check("instr", instr, e.data);
      end
    end
  end

  task automatic drain();
    imem_gnt    = 1'b0;
    instr_ready = 1'b1;
    repeat (4) step();
  endtask

  initial begin
    tests = 0; fails = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    redirect = 0; redirect_pc = 0; instr_ready = 0;
    rsp_en = 0; spurious = 0; cur_rsp_v = 0;
    cur_rsp = '{addr: 32'h0, pc: 32'h0, stale: 1'b1};
    model_pc = RESET_PC;

    // Reset values
    repeat (2) step();
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_addr", imem_addr, RESET_PC);

    // Streaming from reset, crossing the address wrap
    imem_gnt = 1; instr_ready = 1; rsp_en = 1;
    rst_n = 1;
    #1;
    check("first_req", {31'b0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'hFFFF_FFF8);
    step();
    check("first_valid_lat", {31'b0, instr_valid}, 32'd0);
    step();
    check("first_valid", {31'b0, instr_valid}, 32'd1);
    check("first_instr_pc", instr_pc, 32'hFFFF_FFF8);
    check("first_instr", instr, mem_word(32'hFFFF_FFF8));
    check("wrap_addr", imem_addr, 32'h0000_0000);
    repeat (12) step();

    // Decoder back-pressure fills the buffer and throttles requests
    instr_ready = 0;
    repeat (10) step();
    check("bp_req", {31'b0, imem_req}, 32'd0);
    check("bp_valid", {31'b0, instr_valid}, 32'd1);
    instr_ready = 1;
    repeat (8) step();

    // Grant stall: address holds until granted
    drain();
    check("stall_req0", {31'b0, imem_req}, 32'd1);
    check("stall_addr0", imem_addr, model_pc);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_req", {31'b0, imem_req}, 32'd1);
      check("stall_addr", imem_addr, model_pc);
    end
    imem_gnt = 1;
    step();
    check("stall_advance", imem_addr, model_pc);

    // Two requests in flight, redirect to 0x100
    drain();
    rsp_en = 0; imem_gnt = 1;
    repeat (2) step();
    check("inflight_full_req", {31'b0, imem_req}, 32'd0);
    redirect = 1; redirect_pc = 32'h100; rsp_en = 1;
    step();
    redirect = 0;
    for (int i = 0; i < 2; i++) begin
      check("flush_req", {31'b0, imem_req}, 32'd0);
      check("flush_valid", {31'b0, instr_valid}, 32'd0);
      step();
    end
    check("flush_done_req", {31'b0, imem_req}, 32'd1);
    check("flush_done_addr", imem_addr, 32'h100);
    repeat (6) step();

    // Redirect coinciding with a grant and a pop
    drain();
    instr_ready = 0; imem_gnt = 1;
    step();
    imem_gnt = 0;
    step();
    check("setup_valid", {31'b0, instr_valid}, 32'd1);
    check("setup_req", {31'b0, imem_req}, 32'd1);
    imem_gnt = 1; instr_ready = 1; redirect = 1; redirect_pc = 32'h200;
    step();
    redirect = 0;
    check("redir_pop_valid", {31'b0, instr_valid}, 32'd0);
    check("redir_pop_req", {31'b0, imem_req}, 32'd0);
    step();
    check("redir_pop_addr", imem_addr, 32'h200);
    check("redir_pop_req2", {31'b0, imem_req}, 32'd1);
    repeat (6) step();

    // Redirect coinciding with a response
    drain();
    imem_gnt = 1;
    step();
    redirect = 1; redirect_pc = 32'h300;
    step();
    redirect = 0;
    check("redir_rsp_valid", {31'b0, instr_valid}, 32'd0);
    check("redir_rsp_req", {31'b0, imem_req}, 32'd0);
    step();
    check("redir_rsp_addr", imem_addr, 32'h300);
    check("redir_rsp_req2", {31'b0, imem_req}, 32'd1);
    repeat (6) step();

    // Spurious response is ignored; idle redirect stays in FETCH
    drain();
    spurious = 1;
    step();
    spurious = 0;
    step();
    check("spurious_valid", {31'b0, instr_valid}, 32'd0);
    check("spurious_req", {31'b0, imem_req}, 32'd1);
    redirect = 1; redirect_pc = 32'h400;
    step();
    redirect = 0;
    check("idle_redir_req", {31'b0, imem_req}, 32'd1);
    check("idle_redir_addr", imem_addr, 32'h400);
    imem_gnt = 1;
    repeat (6) step();

    // Reset asserted mid-stream
    instr_ready = 0;
    repeat (4) step();
    check("pre_rst_valid", {31'b0, instr_valid}, 32'd1);
    rst_n = 0;
    #1;
    check("mid_rst_req", {31'b0, imem_req}, 32'd0);
    check("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
    check("mid_rst_instr", instr, 32'h0);
    check("mid_rst_instr_pc", instr_pc, 32'h0);
    sb.delete(); memq.delete();
    cur_rsp_v = 0; imem_rvalid = 0; imem_rdata = 0;
    model_pc = RESET_PC; instr_ready = 1;
    repeat (2) step();
    rst_n = 1;
    #1;
    check("refetch_req", {31'b0, imem_req}, 32'd1);
    check("refetch_addr", imem_addr, RESET_PC);
    repeat (10) step();

    imem_gnt = 0;
    repeat (6) step();
    check("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
